// File: rtl/hps2fpga_axi3_mem_slave.sv
// +----------------------------------------------------------------------------+
// | hps2fpga_axi3_mem_slave                                                    |
// | AXI3 slave backed by on-chip word memory, independent read/write paths.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hps2fpga_axi3_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int ID_W        = 12,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [ID_W-1:0]       wid,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int              c_strb_w = DATA_W / 8;
    localparam int              c_lsb    = $clog2(c_strb_w);
    localparam int              c_idx_w  = $clog2(DEPTH_WORDS);
    localparam logic [2:0]      c_lsb3   = 3'(c_lsb);
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W+1)'(DEPTH_WORDS);
    localparam logic [1:0]      c_okay   = 2'b00;
    localparam logic [1:0]      c_slverr = 2'b10;
    localparam logic [1:0]      c_fixed  = 2'b00;
    localparam logic [1:0]      c_wrap   = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_t;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    wr_state_t         r_wr_state;
    logic [ID_W-1:0]   r_awid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [3:0]        r_awlen;
    logic [2:0]        r_awsize;
    logic [1:0]        r_awburst;
    logic [3:0]        r_wr_cnt;
    logic              r_wr_hdr_err;
    logic              r_wr_any_err;

    rd_state_t         r_rd_state;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [3:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;
    logic [3:0]        r_rd_cnt;
    logic              r_rd_hdr_err;

    logic              w_wr_beat_err;
    logic              w_rd_beat_err;
    logic              w_mem_we;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    wire w_unused_sideband = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot};

    // Errors that depend only on the burst header and poison every beat.
    function automatic logic f_hdr_err(input logic [2:0] sz, input logic [3:0] len,
                                       input logic [1:0] bt);
        logic wrap_bad;
        wrap_bad = (bt == c_wrap) &&
                   !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return (sz > c_lsb3) || (bt == 2'b11) || wrap_bad;
    endfunction

    function automatic logic f_range_err(input logic [ADDR_W-1:0] a);
        return {1'b0, (a >> c_lsb)} >= c_depth;
    endfunction

    // WRAP keeps the upper bits of the aligned block and lets only the low bits roll.
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                      input logic [2:0] sz,
                                                      input logic [3:0] len,
                                                      input logic [1:0] bt);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] inc;
        step = ADDR_W'(1) << sz;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
        inc  = a + step;
        if (bt == c_fixed)
            return a;
        else if (bt == c_wrap)
            return (a & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    assign w_wr_idx      = r_wr_addr[c_lsb +: c_idx_w];
    assign w_rd_idx      = r_rd_addr[c_lsb +: c_idx_w];
    assign w_wr_beat_err = r_wr_hdr_err || f_range_err(r_wr_addr) || (wid != r_awid) ||
                           (wlast != (r_wr_cnt == r_awlen));
    assign w_rd_beat_err = r_rd_hdr_err || f_range_err(r_rd_addr);
    assign w_mem_we      = (r_wr_state == W_DATA) && wvalid && wready && !w_wr_beat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state   <= W_IDLE;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bid          <= '0;
            bresp        <= c_okay;
            r_awid       <= '0;
            r_wr_addr    <= '0;
            r_awlen      <= '0;
            r_awsize     <= '0;
            r_awburst    <= '0;
            r_wr_cnt     <= '0;
            r_wr_hdr_err <= 1'b0;
            r_wr_any_err <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        r_awid       <= awid;
                        r_wr_addr    <= awaddr;
                        r_awlen      <= awlen;
                        r_awsize     <= awsize;
                        r_awburst    <= awburst;
                        r_wr_cnt     <= '0;
                        r_wr_hdr_err <= f_hdr_err(awsize, awlen, awburst);
                        r_wr_any_err <= 1'b0;
                        awready      <= 1'b0;
                        wready       <= 1'b1;
                        r_wr_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        r_wr_addr <= f_next_addr(r_wr_addr, r_awsize, r_awlen, r_awburst);
                        r_wr_cnt  <= r_wr_cnt + 4'd1;
                        if (w_wr_beat_err)
                            r_wr_any_err <= 1'b1;
                        if (r_wr_cnt == r_awlen) begin
                            wready     <= 1'b0;
                            bvalid     <= 1'b1;
                            bid        <= r_awid;
                            bresp      <= (r_wr_any_err || w_wr_beat_err) ? c_slverr : c_okay;
                            r_wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid     <= 1'b0;
                        awready    <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (wstrb[b])
                    r_mem[w_wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // The fetch cycle samples memory on the same edge a write may land, so a
    // colliding read sees the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state   <= R_IDLE;
            arready      <= 1'b0;
            rvalid       <= 1'b0;
            rlast        <= 1'b0;
            rid          <= '0;
            rdata        <= '0;
            rresp        <= c_okay;
            r_arid       <= '0;
            r_rd_addr    <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_rd_cnt     <= '0;
            r_rd_hdr_err <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_arid       <= arid;
                        r_rd_addr    <= araddr;
                        r_arlen      <= arlen;
                        r_arsize     <= arsize;
                        r_arburst    <= arburst;
                        r_rd_cnt     <= '0;
                        r_rd_hdr_err <= f_hdr_err(arsize, arlen, arburst);
                        arready      <= 1'b0;
                        r_rd_state   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid <= 1'b1;
                    rid    <= r_arid;
                    rlast  <= (r_rd_cnt == r_arlen);
                    if (w_rd_beat_err) begin
                        rdata <= '0;
                        rresp <= c_slverr;
                    end else begin
                        rdata <= r_mem[w_rd_idx];
                        rresp <= c_okay;
                    end
                    r_rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        if (rlast) begin
                            arready    <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rd_addr  <= f_next_addr(r_rd_addr, r_arsize, r_arlen, r_arburst);
                            r_rd_cnt   <= r_rd_cnt + 4'd1;
                            r_rd_state <= R_FETCH;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hps2fpga_axi3_mem_slave.sv
// +----------------------------------------------------------------------------+
// | tb_hps2fpga_axi3_mem_slave                                                 |
// | Table-driven bench for the AXI3 memory slave plus multi-cycle sequences.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hps2fpga_axi3_mem_slave;

    logic        clk;
    logic        rst_n;
    logic [11:0] awid, wid, bid, arid, rid;
    logic [29:0] awaddr, araddr;
    logic [3:0]  awlen, arlen, awcache, arcache, wstrb;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;

    hps2fpga_axi3_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              wr;
        logic [29:0]     addr;
        logic [3:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [3:0]      strb;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  rsp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int pass_cnt = 0;
    int total    = 0;

    function automatic vec_t mk(input bit wr, input logic [29:0] a, input logic [3:0] l,
                                input logic [2:0] s, input logic [1:0] b, input logic [3:0] st,
                                input logic [127:0] d, input logic [7:0] r);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.size = s; v.burst = b; v.strb = st;
        v.d = d; v.rsp = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        total++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    task automatic do_write(input logic [11:0] id, input logic [29:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [1:0] b, input logic [3:0] st,
                            input logic [3:0][31:0] d, input int lastpos, input logic [11:0] wid_v,
                            output logic [1:0] resp, output logic [11:0] bid_o,
                            output int blat, output logic aw_after);
        int n;
        @(negedge clk);
        awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("aw");
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            wvalid = 1'b1; wdata = d[i]; wstrb = st; wid = wid_v; wlast = (i == lastpos);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) tmo("w");
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        blat = 0;
        while (!bvalid && blat < 50) begin @(negedge clk); blat++; end
        if (blat >= 50) tmo("b");
        resp = bresp; bid_o = bid;
        @(negedge clk);
        bready = 1'b0;
        aw_after = awready;
    endtask

    task automatic do_read(input logic [11:0] id, input logic [29:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [1:0] b,
                           output logic [3:0][31:0] rd, output logic [3:0][1:0] rr,
                           output logic [3:0] rl, output logic [3:0][11:0] ri,
                           output logic [3:0][7:0] lat);
        int n;
        rd = '0; rr = '0; rl = '0; ri = '0; lat = '0;
        @(negedge clk);
        arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("ar");
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(l); i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) tmo("r");
            lat[i] = 8'(n); rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; ri[i] = rid;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]       wresp;
        logic [11:0]      wbid;
        int               blat;
        logic             aw_after;
        logic [3:0][31:0] rd;
        logic [3:0][1:0]  rr;
        logic [3:0]       rl;
        logic [3:0][11:0] ri;
        logic [3:0][7:0]  lat;
        logic [11:0]      id;
        int               n;

        vecs[0]  = mk(1, 30'h100, 4'd3, 3'd2, 2'b01, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h00);
        vecs[1]  = mk(1, 30'h200, 4'd0, 3'd2, 2'b01, 4'hF, 128'h0, 8'h00);
        vecs[2]  = mk(1, 30'h200, 4'd0, 3'd2, 2'b01, 4'h2, 128'hAABBCCDD, 8'h00);
        vecs[3]  = mk(1, 30'hFFC, 4'd1, 3'd2, 2'b01, 4'hF, {64'h0, 32'h66, 32'h55}, 8'h02);
        vecs[4]  = mk(1, 30'h300, 4'd1, 3'd2, 2'b00, 4'hF, {64'h0, 32'h88, 32'h77}, 8'h00);
        vecs[5]  = mk(0, 30'h100, 4'd3, 3'd2, 2'b01, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h00);
        vecs[6]  = mk(0, 30'h108, 4'd3, 3'd2, 2'b10, 4'h0, {32'h22, 32'h11, 32'h44, 32'h33}, 8'h00);
        vecs[7]  = mk(0, 30'h108, 4'd2, 3'd2, 2'b10, 4'h0, 128'h0, 8'b00_10_10_10);
        vecs[8]  = mk(0, 30'h200, 4'd0, 3'd2, 2'b01, 4'h0, 128'h0000CC00, 8'h00);
        vecs[9]  = mk(0, 30'hFFC, 4'd1, 3'd2, 2'b01, 4'h0, 128'h55, 8'b00_00_10_00);
        vecs[10] = mk(0, 30'h104, 4'd1, 3'd2, 2'b00, 4'h0, {64'h0, 32'h22, 32'h22}, 8'h00);
        vecs[11] = mk(0, 30'h300, 4'd0, 3'd2, 2'b01, 4'h0, 128'h88, 8'h00);
        vecs[12] = mk(0, 30'h100, 4'd0, 3'd3, 2'b01, 4'h0, 128'h0, 8'h02);
        vecs[13] = mk(0, 30'h100, 4'd0, 3'd2, 2'b11, 4'h0, 128'h0, 8'h02);
        vecs[14] = mk(0, 30'h102, 4'd1, 3'd1, 2'b01, 4'h0, {64'h0, 32'h22, 32'h11}, 8'h00);
        vecs[15] = mk(0, 30'h104, 4'd1, 3'd2, 2'b10, 4'h0, {64'h0, 32'h11, 32'h22}, 8'h00);

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        awlock = '0; awcache = '0; awprot = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset handshake outs", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
        chk("reset b fields", {bid, bresp}, 14'h0);
        chk("reset r fields", {rid, rresp, rdata}, 46'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", {awready, arready}, 2'b11);

        for (int v = 0; v < NV; v++) begin
            id = 12'(12'h100 + v);
            if (vecs[v].wr) begin
                do_write(id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                         vecs[v].strb, vecs[v].d, int'(vecs[v].len), id,
                         wresp, wbid, blat, aw_after);
                chk($sformatf("v%0d bresp", v), wresp, vecs[v].rsp[0]);
                chk($sformatf("v%0d bid", v), wbid, id);
                chk($sformatf("v%0d bvalid latency", v), blat, 0);
                chk($sformatf("v%0d awready after B", v), aw_after, 1'b1);
            end else begin
                do_read(id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                        rd, rr, rl, ri, lat);
                for (int i = 0; i <= int'(vecs[v].len); i++) begin
                    chk($sformatf("v%0d beat%0d rdata", v, i), rd[i], vecs[v].d[i]);
                    chk($sformatf("v%0d beat%0d rresp", v, i), rr[i], vecs[v].rsp[i]);
                    chk($sformatf("v%0d beat%0d rlast", v, i), rl[i], i == int'(vecs[v].len));
                    chk($sformatf("v%0d beat%0d rid", v, i), ri[i], id);
                    chk($sformatf("v%0d beat%0d rvalid latency", v, i), lat[i], 8'd1);
                end
            end
        end

        // wlast on beat 2 of a 4-beat burst: beats 2 and 4 are in error and dropped
        do_write(12'h7A1, 30'h400, 4'd3, 3'd2, 2'b01, 4'hF,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 12'h7A1, wresp, wbid, blat, aw_after);
        chk("early wlast bresp", wresp, 2'b10);
        chk("early wlast bid", wbid, 12'h7A1);
        do_read(12'h1, 30'h400, 4'd0, 3'd2, 2'b01, rd, rr, rl, ri, lat);
        chk("early wlast beat1 kept", rd[0], 32'hA0);
        do_read(12'h1, 30'h408, 4'd0, 3'd2, 2'b01, rd, rr, rl, ri, lat);
        chk("early wlast beat3 kept", rd[0], 32'hA2);

        // wid mismatch: error response and memory left untouched
        do_write(12'h0C3, 30'h500, 4'd0, 3'd2, 2'b01, 4'hF, 128'h12345678, 0, 12'h0C3,
                 wresp, wbid, blat, aw_after);
        chk("preload bresp", wresp, 2'b00);
        do_write(12'h0C3, 30'h500, 4'd0, 3'd2, 2'b01, 4'hF, 128'hDEADBEEF, 0, 12'h0C4,
                 wresp, wbid, blat, aw_after);
        chk("wid mismatch bresp", wresp, 2'b10);
        chk("wid mismatch bid", wbid, 12'h0C3);
        do_read(12'h2, 30'h500, 4'd0, 3'd2, 2'b01, rd, rr, rl, ri, lat);
        chk("wid mismatch no write", rd[0], 32'h12345678);

        // rready held low: response must stay frozen
        @(negedge clk);
        arid = 12'h3E5; araddr = 30'h100; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("stall ar");
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("stall r");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall cycle%0d", c), {rvalid, rlast, rresp, rid, rdata},
                {1'b1, 1'b1, 2'b00, 12'h3E5, 32'h11});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("stall done rvalid/arready", {rvalid, arready}, 2'b01);

        // reset while beat 2 of a read is being presented
        @(negedge clk);
        arid = 12'h044; araddr = 30'h100; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("rst ar");
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) tmo("rst r");
            if (i == 0) @(negedge clk);
        end
        chk("beat2 data before reset", rdata, 32'h22);
        rst_n = 1'b0; rready = 1'b0;
        @(posedge clk);
        #1;
        chk("rvalid during reset", {rvalid, arready, awready}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid-read reset", {awready, arready}, 2'b11);
        do_read(12'h055, 30'h100, 4'd3, 3'd2, 2'b01, rd, rr, rl, ri, lat);
        chk("post-reset readback", rd, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("post-reset resp/last", {rr, rl}, {8'h00, 4'b1000});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
